uart_rx_word_assembler: RTL
===========================

# uart_rx_word_assembler

Receive-side counterpart to the CPU's UART transmit path. It oversamples the serial line, recovers 8N1 bytes, and packs four consecutive bytes MSB-first into a 32-bit word. The word is held in a register the CPU reads through its memory-mapped load path. It also consumes the 0x0A line delimiter that the transmit side appends after each word.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 8
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- rx_serial  in  1  raw UART line, idle high; asynchronous to clk
- memread  in  1  CPU load strobe; consumes the held word
- readdata  out  32  last completed word; first byte received in [31:24]
- rx_valid  out  1  readdata holds an unread word
- rx_overrun  out  1  sticky: a word completed while rx_valid=1 and was dropped
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low

## Operation
- rx_serial passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
- Bit FSM states:
  - IDLE: leave on rx_s=0 to START, counter cleared.
  - START: at counter=(CLKS_PER_BIT-1)/2, go to DATA if rx_s=0; otherwise return to IDLE (glitch rejected).
  - DATA: one sample every CLKS_PER_BIT cycles; 8 samples, LSB first, 3-bit bit index.
  - STOP: sample after a further CLKS_PER_BIT cycles. rx_s=1 means a good byte; rx_s=0 means framing error. Then go to IDLE.
- Word assembly on each good byte: shift = {shift[23:0], byte}, byte_idx += 1 (2 bits).
- When byte_idx=3 and a good byte arrives, the word completes and byte_idx wraps to 0.
- Word completion:
  - rx_valid=0: readdata ← word, rx_valid←1.
  - rx_valid=1 without memread that cycle: word dropped, readdata unchanged, rx_overrun←1.
- memread with rx_valid=1: rx_valid←0 and rx_overrun←0 on the next edge.
- memread and word completion in the same cycle: readdata ← new word, rx_valid stays 1, no overrun.
- memread while rx_valid=0: no effect.
- Framing error: byte discarded, byte_idx←0, partial shift discarded, rx_frame_err pulses 1 cycle.
- Reset (any time, including mid-byte): FSM←IDLE, counters, byte_idx, and shift←0. Outputs reset to readdata=0, rx_valid=0, rx_overrun=0, rx_frame_err=0. Synchronizer flops reset to 1.

## Timing
- Start detect: 2 cycles after the line falls (synchronizer).
- Sample points: start bit mid-check (CLKS_PER_BIT-1)/2 cycles after detect. Data bit n at that point + (n+1)·CLKS_PER_BIT; stop bit at that point + 9·CLKS_PER_BIT.
- rx_valid, readdata, rx_overrun, and rx_frame_err update on the clock edge after the stop-bit sample cycle.
- FSM is in IDLE the cycle after the stop sample, so back-to-back frames are received with no gap required.
- readdata is stable whenever rx_valid=1 and changes only on accepted completion or reset.

## Configuration
- UART_RX_NEWLINE_SYNC_EN defined:
  - A good byte equal to 0x0A received while byte_idx=0 is discarded; byte_idx and shift are unchanged.
  - 0x0A at byte_idx 1–3 is word data.
  - This re-aligns word boundaries to the transmit side's 4-bytes-plus-newline framing.
- Undefined: every good byte, including 0x0A, is word data.

## Test plan
- CLKS_PER_BIT=16; send 0xDE,0xAD,0xBE,0xEF back-to-back -> readdata=0xDEADBEEF and rx_valid=1 one cycle after the 4th stop sample; memread -> rx_valid=0 next cycle.
- Macro defined; send 0x0A,0x12,0x34,0x56,0x78,0x0A -> one word 0x12345678; both newlines dropped; byte_idx=0 at end. Macro undefined, same stimulus -> word 0x0A123456, byte_idx=2.
- Two words 0x11111111 then 0x22222222 with no memread -> readdata=0x11111111, rx_overrun=1; memread -> rx_valid=0 and rx_overrun=0. Third word completing in the same cycle as memread -> readdata updates and rx_valid stays 1.
- Send 0xAB with stop bit forced low, then 0x01,0x02,0x03,0x04 -> rx_frame_err pulses once; readdata=0x01020304.
- 4-cycle low glitch on an idle line -> FSM returns to IDLE from START; no byte and no error.
- Assert reset mid-DATA after 2 bytes of a word -> all outputs 0; the following 4 bytes 0xCAFEF00D assemble to 0xCAFEF00D.

Source files
------------

// File: rtl/uart_rx_word_assembler.sv
// 8N1 UART receiver that packs four bytes MSB-first into a CPU-readable word.
// Define UART_RX_NEWLINE_SYNC_EN to drop 0x0A delimiters at word boundaries.
module uart_rx_word_assembler #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_serial,
  input  logic        memread,
  output logic [31:0] readdata,
  output logic        rx_valid,
  output logic        rx_overrun,
  output logic        rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    rx_byte, rx_byte_n;
  logic          sync_m, rx_s;
  logic          good, bad;

  logic [23:0]   shift;
  logic [1:0]    byte_idx;
  logic          keep, complete;
  logic [31:0]   word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_m <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_m <= rx_serial;
      rx_s   <= sync_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      rx_byte <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      rx_byte <= rx_byte_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    rx_byte_n = rx_byte;
    good      = 1'b0;
    bad       = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n     = '0;
          rx_byte_n = {rx_s, rx_byte[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          good    = rx_s;
          bad     = !rx_s;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef UART_RX_NEWLINE_SYNC_EN
  // A newline at a word boundary is framing, not data
  assign keep = good && !(rx_byte == 8'h0A && byte_idx == 2'd0);
`else
  assign keep = good;
`endif

  assign word     = {shift, rx_byte};
  assign complete = keep && (byte_idx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift    <= '0;
      byte_idx <= '0;
    end else if (bad) begin
      shift    <= '0;
      byte_idx <= '0;
    end else if (keep) begin
      shift    <= word[23:0];
      byte_idx <= byte_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata     <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= bad;
      if (complete) begin
        // A read in the same cycle frees the slot for the new word
        if (!rx_valid || memread) begin
          readdata <= word;
          rx_valid <= 1'b1;
          if (memread) rx_overrun <= 1'b0;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (memread && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end

endmodule
